// File: rtl/spectrum_smoother.sv
// spectrum_smoother
//  Sits between the FFT core and the graphics controller. On each rising edge of
//  fft_done it walks the magnitude bins one per clock, shifts and saturates each one
//  to GFX_WIDTH bits, applies instant-attack / linear-decay smoothing into a shadow
//  store, and then copies the whole shadow to bar_level in a single edge so the
//  display never sees a half-updated frame.
//
//  Optional feature macro: PEAK_HOLD_EN (adds per-bin peak markers with hold timer).
//  Without it, o_peak_level is tied to zero and no peak/hold storage exists.
//
//  Timing (T = edge that samples the fft_done rise):
//    edges T+1..T+N_BINS  scan bins 0..N_BINS-1
//    edge  T+N_BINS+1     bar_level/peak_level load, frame_valid rises for one cycle
//    o_busy is high from edge T until edge T+N_BINS+1.
//
//  Ports
//    i_clk          FFT clock
//    i_rst          asynchronous, active-high reset
//    i_fft_done     FFT done level; i_freq_mag stable while high
//    i_freq_mag     [WIDTH:0] x N_BINS magnitudes
//    i_shift        right-shift gain control
//    o_bar_level    [GFX_WIDTH-1:0] x N_BINS published smoothed levels
//    o_peak_level   [GFX_WIDTH-1:0] x N_BINS published peak markers
//    o_frame_valid  one-cycle pulse coincident with new bar_level
//    o_busy         frame in progress (SCAN or PUBLISH)
//    o_overrun      sticky; a fft_done rise arrived while busy (cleared by reset only)
//
//  state     | meaning
//  S_IDLE    | waiting for a fft_done rise
//  S_SCAN    | processing bin r_idx, one per clock
//  S_PUBLISH | copying shadow to outputs, pulsing frame_valid
module spectrum_smoother #(
   parameter int N_BINS      = 101,
   parameter int WIDTH       = 18,
   parameter int GFX_WIDTH   = 6,
   parameter int DECAY       = 2,
   parameter int HOLD_FRAMES = 30
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_fft_done,
   input  logic [WIDTH:0]       i_freq_mag   [N_BINS],
   input  logic [3:0]           i_shift,
   output logic [GFX_WIDTH-1:0] o_bar_level  [N_BINS],
   output logic [GFX_WIDTH-1:0] o_peak_level [N_BINS],
   output logic                 o_frame_valid,
   output logic                 o_busy,
   output logic                 o_overrun
);

   localparam int                  IDX_W    = (N_BINS > 1) ? $clog2(N_BINS) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_BINS - 1);
   localparam logic [GFX_WIDTH-1:0] DECAY_G = GFX_WIDTH'(DECAY);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUBLISH} state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_done_d;
   logic [GFX_WIDTH-1:0] r_shadow [N_BINS];

   logic                 w_trigger;
   logic [WIDTH:0]       w_shifted;
   logic [GFX_WIDTH-1:0] w_sc;
   logic [GFX_WIDTH-1:0] w_decayed;
   logic [GFX_WIDTH-1:0] w_next;

   assign w_trigger = i_fft_done & ~r_done_d;
   assign w_shifted = i_freq_mag[r_idx] >> i_shift;
   // Any set bit above the bar width means the value does not fit: clamp to full scale.
   assign w_sc      = (|w_shifted[WIDTH:GFX_WIDTH]) ? '1 : w_shifted[GFX_WIDTH-1:0];
   // Decay floors at zero rather than wrapping.
   assign w_decayed = (r_shadow[r_idx] > DECAY_G) ? (r_shadow[r_idx] - DECAY_G) : '0;
   assign w_next    = (w_sc > w_decayed) ? w_sc : w_decayed;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_done_d      <= 1'b0;
         o_frame_valid <= 1'b0;
         o_busy        <= 1'b0;
         o_overrun     <= 1'b0;
         for (int i = 0; i < N_BINS; i++) begin
            r_shadow[i]    <= '0;
            o_bar_level[i] <= '0;
         end
      end else begin
         r_done_d      <= i_fft_done;
         o_frame_valid <= 1'b0;
         // A rise during PUBLISH also counts as busy and is dropped.
         if (w_trigger && (r_state != S_IDLE)) o_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_state <= S_SCAN;
                  r_idx   <= '0;
                  o_busy  <= 1'b1;
               end
            end
            S_SCAN: begin
               r_shadow[r_idx] <= w_next;
               if (r_idx == LAST_IDX) r_state <= S_PUBLISH;
               else                   r_idx   <= r_idx + 1'b1;
            end
            S_PUBLISH: begin
               for (int i = 0; i < N_BINS; i++) o_bar_level[i] <= r_shadow[i];
               o_frame_valid <= 1'b1;
               o_busy        <= 1'b0;
               r_idx         <= '0;
               r_state       <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PEAK_HOLD_EN
   localparam int               HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_G = HOLD_W'(HOLD_FRAMES);

   logic [GFX_WIDTH-1:0] r_peak [N_BINS];
   logic [HOLD_W-1:0]    r_hold [N_BINS];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < N_BINS; i++) begin
            r_peak[i]       <= '0;
            r_hold[i]       <= '0;
            o_peak_level[i] <= '0;
         end
      end else if (r_state == S_SCAN) begin
         // Peak follows the raw scaled value, not the smoothed bar.
         if (w_sc >= r_peak[r_idx]) begin
            r_peak[r_idx] <= w_sc;
            r_hold[r_idx] <= HOLD_G;
         end else if (r_hold[r_idx] != '0) begin
            r_hold[r_idx] <= r_hold[r_idx] - 1'b1;
         end else if (r_peak[r_idx] != '0) begin
            r_peak[r_idx] <= r_peak[r_idx] - 1'b1;
         end
      end else if (r_state == S_PUBLISH) begin
         for (int i = 0; i < N_BINS; i++) o_peak_level[i] <= r_peak[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < N_BINS; i++) o_peak_level[i] = '0;
   end
`endif

endmodule
